// File: rtl/mem_req_ctrl_if.sv
// SRAM-like data bus between the request controller (master) and the data
// memory or its bridge (slave). Only one transaction may be outstanding.
interface mem_req_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Data-side request controller between the execute-stage ALU and the
// memory stage. It checks alignment, issues one SRAM-like request at a time,
// extracts and extends load data, and stalls execute until the access is
// consumed. A flush with a request in flight marks it killed. The bus
// transaction still drains to data_ok, but its result is dropped.
module mem_req_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  es_valid,
    input  logic                  ex_block,
    input  logic                  mem_re,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic                  mem_sext,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           store_data,
    input  logic                  out_ready,
    mem_req_ctrl_if.master        bus,
    output logic                  mem_stall,
    output logic                  result_valid,
    output logic [31:0]           load_result,
    output logic                  adel,
    output logic                  ades,
    output logic [31:0]           badvaddr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic        kill_q;
    logic        req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        sext_q;
    logic        rvalid_q;
    logic [31:0] result_q;

    logic        access_s;
    logic        misalign_s;
    logic [1:0]  size_norm_s;
    logic [31:0] wdata_d;
    logic [31:0] shifted_s;
    logic [31:0] load_ext_d;

    assign access_s    = es_valid & (mem_re | mem_we) & ~ex_block;
    assign size_norm_s = (mem_size == 2'd3) ? 2'd2 : mem_size;

    // Alignment check on the incoming access (size 3 behaves as word).
    always_comb begin
        misalign_s = 1'b0;
        case (mem_size)
            2'd0:    misalign_s = 1'b0;
            2'd1:    misalign_s = mem_addr[0];
            default: misalign_s = (mem_addr[1:0] != 2'd0);
        endcase
    end

    // Replicate store data across byte lanes so the slave can pick any lane.
    always_comb begin
        wdata_d = store_data;
        case (size_norm_s)
            2'd0:    wdata_d = {4{store_data[7:0]}};
            2'd1:    wdata_d = {2{store_data[15:0]}};
            default: wdata_d = store_data;
        endcase
    end

    assign shifted_s = bus.data_rdata >> {addr_q[1:0], 3'b000};

    // Truncate the lane-aligned read data to the latched size and extend it.
    always_comb begin
        load_ext_d = shifted_s;
        case (size_q)
            2'd0: begin
                if (sext_q) begin
                    load_ext_d = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end else begin
                    load_ext_d = {24'h000000, shifted_s[7:0]};
                end
            end
            2'd1: begin
                if (sext_q) begin
                    load_ext_d = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end else begin
                    load_ext_d = {16'h0000, shifted_s[15:0]};
                end
            end
            default: load_ext_d = shifted_s;
        endcase
    end

    // Request FSM with registered bus outputs and result; a kill marks a draining transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kill_q   <= 1'b0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            sext_q   <= 1'b0;
            rvalid_q <= 1'b0;
            result_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    kill_q <= 1'b0;
                    if (access_s & ~misalign_s & ~flush) begin
                        wr_q    <= mem_we;
                        size_q  <= size_norm_s;
                        addr_q  <= mem_addr;
                        wdata_q <= wdata_d;
                        sext_q  <= mem_sext;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // data_ok here cannot belong to this request and is ignored.
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (bus.data_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.data_data_ok) begin
                        if (kill_q | flush) begin
                            kill_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            result_q <= wr_q ? 32'h0000_0000 : load_ext_d;
                            rvalid_q <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush | out_ready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    kill_q   <= 1'b0;
                    req_q    <= 1'b0;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

    assign result_valid = rvalid_q;
    assign load_result  = result_q;

    // Execute is held until this access's own result is being consumed.
    assign mem_stall = access_s & ~misalign_s &
                       ~((state_q == S_DONE) & ~kill_q & out_ready);

    assign adel     = ~reset & access_s & mem_re & misalign_s;
    assign ades     = ~reset & access_s & mem_we & misalign_s;
    assign badvaddr = mem_addr;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl. Expected load results are queued when an
// access is offered and popped when the controller reports result_valid.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        es_valid;
    logic        ex_block;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_sext;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic        out_ready;
    logic        mem_stall;
    logic        result_valid;
    logic [31:0] load_result;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    mem_req_ctrl_if bus ();

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_req_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .es_valid     (es_valid),
        .ex_block     (ex_block),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_sext     (mem_sext),
        .mem_addr     (mem_addr),
        .store_data   (store_data),
        .out_ready    (out_ready),
        .bus          (bus.master),
        .mem_stall    (mem_stall),
        .result_valid (result_valid),
        .load_result  (load_result),
        .adel         (adel),
        .ades         (ades),
        .badvaddr     (badvaddr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (obs=running exp=finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic we, input logic [1:0] sz,
                                               input logic sx, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        if (we) return 32'h0000_0000;
        case (a[1:0])
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'd0:    return sx ? {{24{b[7]}}, b} : {24'h000000, b};
            2'd1:    return sx ? {{16{h[15]}}, h} : {16'h0000, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
        case (sz)
            2'd0:    return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            2'd1:    return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    task automatic offer(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] sd);
        es_valid   = 1'b1;
        ex_block   = 1'b0;
        mem_re     = ~we;
        mem_we     = we;
        mem_size   = sz;
        mem_sext   = sx;
        mem_addr   = a;
        store_data = sd;
    endtask

    task automatic drop_access();
        es_valid = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
    endtask

    // Starts with the controller in its first REQ cycle and the access still offered.
    task automatic serve(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int hold, input logic early);
        logic [1:0] exp_sz;
        exp_sz = (sz == 2'd3) ? 2'd2 : sz;
        chk("req_up", 32'(bus.data_req), 32'd1);
        chk("req_addr", bus.data_addr, a);
        chk("req_wr", 32'(bus.data_wr), 32'(we));
        chk("req_size", 32'(bus.data_size), 32'(exp_sz));
        chk("req_wdata", bus.data_wdata, model_wdata(exp_sz, sd));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("req_hold", 32'(bus.data_req), 32'd1);
            chk("addr_hold", bus.data_addr, a);
        end
        bus.data_addr_ok = 1'b1;
        if (early) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = 32'h5A5A_5A5A;
        end
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        chk("req_dropped", 32'(bus.data_req), 32'd0);
        chk("no_early_valid", 32'(result_valid), 32'd0);
        if (early) begin
            @(posedge clk); #1;
            chk("early_ok_ignored", 32'(result_valid), 32'd0);
        end
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rd;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0000_0000;
        chk("result_valid", 32'(result_valid), 32'd1);
        if (result_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=%0d expected=%0d", 0, 1);
            end
            if (exp_q.size() > 0) chk("load_result", load_result, exp_q.pop_front());
        end
        chk("stall_done", 32'(mem_stall), 32'd0);
        drop_access();
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(result_valid), 32'd0);
        chk("idle_no_req", 32'(bus.data_req), 32'd0);
    endtask

    task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int hold, input logic early);
        offer(we, sz, sx, a, sd);
        out_ready = 1'b1;
        exp_q.push_back(model_load(we, sz, sx, a, rd));
        #1;
        chk("stall_accept", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        serve(we, sz, a, sd, rd, hold, early);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        es_valid = 1'b0; ex_block = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        mem_size = 2'd0; mem_sext = 1'b0; mem_addr = 32'h0; store_data = 32'h0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        offer(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0);
        #1;
        chk("rst_adel_forced", 32'(adel), 32'd0);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_addr", bus.data_addr, 32'h0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", load_result, 32'h0);
        drop_access();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Word load, then byte/half loads with lane extraction and extension.
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b1);
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_1234, 2, 1'b0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_1004, 32'h0, 32'h1357_9BDF, 0, 1'b0);

        // Stores: half and byte lane replication, result reads back as 0.
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, 1'b0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h1234_56C3, 32'h0, 1, 1'b0);

        // Misaligned accesses raise address errors without any request.
        offer(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0);
        #1;
        chk("adel", 32'(adel), 32'd1);
        chk("adel_ades", 32'(ades), 32'd0);
        chk("adel_badvaddr", badvaddr, 32'h0000_1001);
        chk("adel_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("adel_no_req", 32'(bus.data_req), 32'd0);
        offer(1'b1, 2'd2, 1'b0, 32'h0000_1002, 32'h0);
        #1;
        chk("ades", 32'(ades), 32'd1);
        chk("ades_badvaddr", badvaddr, 32'h0000_1002);
        @(posedge clk); #1;
        chk("ades_no_req", 32'(bus.data_req), 32'd0);
        offer(1'b0, 2'd1, 1'b1, 32'h0000_1003, 32'h0);
        #1;
        chk("lh_odd_adel", 32'(adel), 32'd1);
        ex_block = 1'b1;
        mem_size = 2'd2;
        mem_addr = 32'h0000_1000;
        #1;
        chk("exblock_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("exblock_no_req", 32'(bus.data_req), 32'd0);
        drop_access();
        ex_block = 1'b0;

        // Flush together with a new access in IDLE issues nothing.
        offer(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drop_access();
        chk("flush_idle_no_req", 32'(bus.data_req), 32'd0);
        @(posedge clk); #1;
        chk("flush_idle_no_req2", 32'(bus.data_req), 32'd0);

        // Slow addr_ok, then flush in WAIT; the killed data must be swallowed.
        offer(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0);
        @(posedge clk); #1;
        chk("slow_req", 32'(bus.data_req), 32'd1);
        chk("slow_addr", bus.data_addr, 32'h0000_3000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("slow_req_stable", 32'(bus.data_req), 32'd1);
            chk("slow_addr_stable", bus.data_addr, 32'h0000_3000);
        end
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        flush = 1'b1;
        drop_access();
        @(posedge clk); #1;
        flush = 1'b0;
        offer(1'b0, 2'd0, 1'b0, 32'h0000_4001, 32'h0);
        exp_q.push_back(model_load(1'b0, 2'd0, 1'b0, 32'h0000_4001, 32'hCAFE_7700));
        #1;
        chk("drain_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        chk("drain_no_req", 32'(bus.data_req), 32'd0);
        chk("drain_stall2", 32'(mem_stall), 32'd1);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1111_1111;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        chk("killed_no_valid", 32'(result_valid), 32'd0);
        chk("killed_no_req", 32'(bus.data_req), 32'd0);
        chk("killed_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        serve(1'b0, 2'd0, 32'h0000_4001, 32'h0, 32'hCAFE_7700, 0, 1'b0);

        // Asynchronous reset while waiting for data; a late data_ok is ignored.
        offer(1'b0, 2'd1, 1'b1, 32'h0000_5002, 32'h0);
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        drop_access();
        chk("pre_rst_result", load_result, 32'h0000_0077);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(bus.data_req), 32'd0);
        chk("arst_addr", bus.data_addr, 32'h0);
        chk("arst_size", 32'(bus.data_size), 32'd0);
        chk("arst_result", load_result, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h2222_2222;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        chk("late_ok_valid", 32'(result_valid), 32'd0);
        chk("late_ok_req", 32'(bus.data_req), 32'd0);
        @(posedge clk); #1;
        chk("late_ok_valid2", 32'(result_valid), 32'd0);
        chk("late_ok_result", load_result, 32'h0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Data-side SRAM-like request controller between the execute-stage ALU and the memory stage. It takes the ALU's `mem_addr` plus load/store control for the instruction in execute and performs address-alignment checks. It issues one request at a time on the SRAM-like data bus, then extracts and sign/zero-extends load data. It stalls execute until the access completes and handles pipeline flushes with a transaction still outstanding.

## Interface
Parameters: none.

Clock and reset are `clk` and `reset`: one clock, reset asynchronous and active-high.

- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high.
- `flush` in 1 — exception/eret flush; kills the current access.
- `es_valid` in 1 — an instruction is valid in execute.
- `ex_block` in 1 — that instruction already carries an exception; it must not access memory.
- `mem_re` in 1 — load.
- `mem_we` in 1 — store. `mem_re` and `mem_we` are never both 1.
- `mem_size` in 2 — 0 byte, 1 half, 2 word; 3 is illegal and treated as word.
- `mem_sext` in 1 — sign-extend load data.
- `mem_addr` in 32 — effective address from the ALU.
- `store_data` in 32 — rt value.
- `out_ready` in 1 — memory stage accepts the result (ms_allowin).
- `data_req` out 1 — SRAM-like request.
- `data_wr` out 1 — request is a write.
- `data_size` out 2 — request size.
- `data_addr` out 32 — full byte address (not aligned down).
- `data_wdata` out 32 — write data.
- `data_addr_ok` in 1 — slave accepted the address.
- `data_data_ok` in 1 — read data or write acknowledge returned.
- `data_rdata` in 32 — read data.
- `mem_stall` out 1 — hold execute.
- `result_valid` out 1 — `load_result` is valid.
- `load_result` out 32 — extracted load value; 0 for stores.
- `adel` out 1 — load address error.
- `ades` out 1 — store address error.
- `badvaddr` out 32 — faulting address.

## Operation
- `access = es_valid & (mem_re|mem_we) & ~ex_block`.
- `misalign = (size==1 & addr[0]) | (size>=2 & addr[1:0]!=0)`.
- `adel = access & mem_re & misalign`; `ades = access & mem_we & misalign`; `badvaddr = mem_addr`. All three are combinational.
- A misaligned access issues no request and raises no stall.
- FSM states: IDLE, REQ, WAIT, DONE. A `kill` flag register marks a flushed transaction.
- IDLE: if `access & ~misalign & ~flush`, latch wr, size, addr, sext and the replicated wdata, then go to REQ.
  - Byte wdata = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- REQ: `data_req=1`, with all request outputs driven from the latched registers and stable. `data_addr_ok` moves to WAIT.
- WAIT: `data_data_ok` moves to DONE, or to IDLE when `kill` is set.
  - On load, `load_result` captures `data_rdata >> (8*addr[1:0])` truncated to the size, sign- or zero-extended by sext.
  - On store, `load_result` is 0.
- DONE: `result_valid=1`. With `out_ready` go to IDLE.
- Flush:
  - In IDLE or DONE: go to IDLE immediately.
  - In REQ or WAIT: set `kill`. The request is not withdrawn; the transaction runs to `data_data_ok`, its data is discarded, and `result_valid` is never raised.
  - `kill` clears on return to IDLE.
- `mem_stall = access & ~misalign & ~(state==DONE & ~kill & out_ready)`. It is also 1 in IDLE whenever state≠IDLE would block, i.e. the stall holds while any earlier transaction is still draining.
- At most one outstanding transaction.

## Timing
- Reset values:
  - state IDLE, `kill` 0.
  - `data_req` 0, `data_wr` 0, `data_size` 0, `data_addr` 0, `data_wdata` 0.
  - `result_valid` 0, `load_result` 0.
  - `adel`/`ades` 0 (forced while `reset`).
- Reset is asynchronous; taken mid-transaction it returns to IDLE with no drain.
- Latency: the request appears the cycle after `access` is sampled in IDLE.
- With `addr_ok` in the first REQ cycle and `data_ok` one cycle later, `result_valid` asserts 3 cycles after acceptance. `mem_stall` drops in the DONE cycle if `out_ready`.
- `data_addr_ok` and `data_data_ok` arriving in the same cycle while in REQ: go to WAIT; that `data_ok` is ignored, since it cannot belong to this request.
- `data_data_ok` outside WAIT is ignored.
- `flush` and `data_data_ok` in the same WAIT cycle: discard the data, go to IDLE.
- `flush` in IDLE together with a new `access`: no request is issued.

## Test plan
- Word load: addr 0x1000, `data_addr_ok` on the first REQ cycle, `data_data_ok` next with rdata 0xDEADBEEF. Expected: `data_req` asserted for 1 cycle, `load_result`=0xDEADBEEF, `result_valid` for 1 cycle with `out_ready`=1, `mem_stall` low afterwards.
- lb at addr 0x1003, sext=1, rdata 0x80FF1234. Expected: `load_result`=0xFFFFFF80. Same case as lbu: 0x00000080. lh at 0x1002: 0xFFFF80FF.
- sh at 0x2002 with `store_data` 0x0000ABCD. Expected: `data_wr`=1, `data_size`=1, `data_wdata`=0xABCDABCD, `data_addr`=0x2002, `result_valid` with `load_result` 0.
- lw at 0x1001. Expected: `adel`=1, `badvaddr`=0x1001, `data_req` never asserts, `mem_stall`=0. sw at 0x1002: `ades`=1.
- `data_addr_ok` held low 5 cycles. Expected: `data_req` and `data_addr` stable for all 5 cycles. Then `flush` in WAIT, and a new access offered the next cycle. Expected: the old `data_ok` is swallowed with no `result_valid`, `mem_stall` stays high, and the new request issues only after the drain.
- `reset` asserted in WAIT. Expected: all outputs return to 0 asynchronously, state is IDLE, and a late `data_data_ok` is ignored.
